ldst_sequencer: RTL and testbench

LDST_SEQUENCER -- requirements
Module: ldst_sequencer

---
 rtl/ldst_sequencer_pkg.sv | 28 ++
 rtl/ldst_sequencer_handshake_timer.sv | 32 +++
 rtl/ldst_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ldst_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_sequencer_pkg.sv
// Shared types and encodings for the load/store instruction sequencer.
// Holds the FSM state enum, supported opcodes and the ALU add select.
package ldst_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, WAIT_MEM, WAIT_ALU, DONE, ERR
  } state_e;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [5:0] ALU_ADD = 6'b000100;

  function automatic logic is_known_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  // A memory wait resumes at the step after the one that issued the access.
  function automatic state_e mem_return(input state_e src);
    case (src)
      T1:      return T2;
      T6:      return T7;
      default: return DONE;
    endcase
  endfunction

endpackage

// File: rtl/ldst_sequencer_handshake_timer.sv
// Wait-cycle counter for memory/ALU handshakes; flags the last allowed
// waiting cycle when no finished indication is present.
module handshake_timer #(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic Clock,
  input  logic clear,
  input  logic clr,
  input  logic en,
  input  logic done_in,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge Clock) begin
    if (!clear) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The MEM_TIMEOUT-th waiting cycle is the last one; a finish then still wins.
  assign expired = en && !done_in && (r_cnt == LAST_CNT);

endmodule

// File: rtl/ldst_sequencer.sv
// Control sequencer for LD / LDI / ST instructions with bounded waits on
// memory and ALU handshakes. Outputs are a Moore decode of registered state.
//
//   state    | meaning
//   IDLE     | waiting for go
//   T0       | increment PC
//   T1       | instruction fetch request
//   T2       | load IR from MDR (opcode captured at the end of this step)
//   T3       | base register onto bus into RY
//   T4       | immediate + base into RZ, ALU start
//   T5       | effective address to MAR (LD/ST) or to Ra (LDI)
//   T6       | LD: read request / ST: store data into MDR
//   T7       | LD: MDR into Ra / ST: write request
//   WAIT_MEM | holding the issuing step's outputs until mem_finished
//   WAIT_ALU | holding T4 outputs (start low) until alu_finished
//   DONE     | one-cycle done pulse
//   ERR      | timeout or unknown opcode; waits for go
module ldst_sequencer #(
  parameter int OPSEL_W     = 6,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               go,
  input  logic [4:0]         opcode,
  input  logic               alu_finished,
  input  logic               mem_finished,
  output logic               PCout,
  output logic               IncPC,
  output logic               MARin,
  output logic               Read,
  output logic               Write,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Gra,
  output logic               Grb,
  output logic               BAout,
  output logic               Rout,
  output logic               Rin,
  output logic               RYin,
  output logic               Immout,
  output logic               RZin,
  output logic               RZLOout,
  output logic               start,
  output logic [OPSEL_W-1:0] opSelect,
  output logic               busy,
  output logic               done,
  output logic               error
);

  import ldst_sequencer_pkg::*;

  state_e     r_state;
  state_e     r_src;
  state_e     w_next;
  state_e     w_view;
  logic [4:0] r_op;
  logic       w_in_wait;
  logic       w_clr;
  logic       w_fin;
  logic       w_expired;
  logic       w_ld;
  logic       w_ldi;

  assign w_in_wait = (r_state == WAIT_MEM) || (r_state == WAIT_ALU);
  assign w_clr     = !w_in_wait;
  assign w_fin     = (r_state == WAIT_MEM) ? mem_finished : alu_finished;
  assign w_ld      = (r_op == OP_LD);
  assign w_ldi     = (r_op == OP_LDI);

  handshake_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .Clock  (Clock),
    .clear  (clear),
    .clr    (w_clr),
    .en     (w_in_wait),
    .done_in(w_fin),
    .expired(w_expired)
  );

  always_ff @(posedge Clock) begin
    if (!clear) begin
      r_state <= IDLE;
      r_src   <= IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next == WAIT_MEM) && !w_in_wait) r_src <= r_state;
      if (r_state == T2) r_op <= opcode;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_view   = r_state;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    BAout    = 1'b0;
    Rout     = 1'b0;
    Rin      = 1'b0;
    RYin     = 1'b0;
    Immout   = 1'b0;
    RZin     = 1'b0;
    RZLOout  = 1'b0;
    opSelect = '0;
    start    = (r_state == T4);
    busy     = (r_state != IDLE) && (r_state != ERR);
    done     = (r_state == DONE);
    error    = (r_state == ERR);

    case (r_state)
      IDLE:     if (go) w_next = T0;
      T0:       w_next = T1;
      T1:       w_next = WAIT_MEM;
      T2:       w_next = T3;
      T3:       w_next = is_known_op(r_op) ? T4 : ERR;
      T4:       w_next = WAIT_ALU;
      T5:       w_next = w_ldi ? DONE : T6;
      T6:       w_next = w_ld ? WAIT_MEM : T7;
      T7:       w_next = w_ld ? DONE : WAIT_MEM;
      WAIT_MEM: begin
        w_view = r_src;
        if (mem_finished)   w_next = mem_return(r_src);
        else if (w_expired) w_next = ERR;
      end
      WAIT_ALU: begin
        w_view = T4;
        if (alu_finished)   w_next = T5;
        else if (w_expired) w_next = ERR;
      end
      DONE:     w_next = IDLE;
      ERR:      if (go) w_next = T0;
      default:  w_next = IDLE;
    endcase

    case (w_view)
      T0: IncPC = 1'b1;
      T1: begin
        PCout = 1'b1;
        MARin = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Rout  = 1'b1;
        RYin  = 1'b1;
      end
      T4: begin
        Immout   = 1'b1;
        RZin     = 1'b1;
        opSelect = OPSEL_W'(ALU_ADD);
      end
      T5: begin
        RZLOout = 1'b1;
        if (w_ldi) begin
          Gra = 1'b1;
          Rin = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      T6: begin
        MDRin = 1'b1;
        if (w_ld) begin
          Read = 1'b1;
        end else begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
      end
      T7: begin
        if (w_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer: micro-program interpreter model compared every
// cycle, directed instruction scenarios with literal expectations, random run.
module tb_ldst_sequencer;
  import ldst_sequencer_pkg::*;

  localparam int OPW = 6;
  localparam int TW  = 8;
  localparam int MT  = 10;

  // micro-step codes used by the model's programs
  localparam int S_T0 = 0, S_T1 = 1, S_T2 = 2, S_T3 = 3, S_T4 = 4, S_T5 = 5;
  localparam int S_T6 = 6, S_T7 = 7, S_WM = 8, S_WA = 9, S_DN = 10;

  logic           Clock = 1'b0;
  logic           clear, go, alu_finished, mem_finished;
  logic [4:0]     opcode;
  logic           PCout, IncPC, MARin, Read, Write, MDRin, MDRout, IRin;
  logic           Gra, Grb, BAout, Rout, Rin, RYin, Immout, RZin, RZLOout, start;
  logic [OPW-1:0] opSelect;
  logic           busy, done, error;
  logic [26:0]    dut_vec;

  ldst_sequencer #(.OPSEL_W(OPW), .TIMEOUT_W(TW), .MEM_TIMEOUT(MT)) dut (
    .Clock(Clock), .clear(clear), .go(go), .opcode(opcode),
    .alu_finished(alu_finished), .mem_finished(mem_finished),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Read(Read), .Write(Write),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb),
    .BAout(BAout), .Rout(Rout), .Rin(Rin), .RYin(RYin), .Immout(Immout),
    .RZin(RZin), .RZLOout(RZLOout), .start(start), .opSelect(opSelect),
    .busy(busy), .done(done), .error(error)
  );

  assign dut_vec = {PCout, IncPC, MARin, Read, Write, MDRin, MDRout, IRin, Gra, Grb,
                    BAout, Rout, Rin, RYin, Immout, RZin, RZLOout, start,
                    opSelect, busy, done, error};

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // ---------------- model ----------------
  int         prog[$];
  int         m_idx   = 0;
  int         m_phase = 0;   // 0 idle, 1 running a program, 2 error
  int         m_wcnt  = 0;
  bit         m_valid = 1'b0;
  logic [4:0] m_op    = '0;

  task automatic model_step();
    int  s;
    bit  adv;
    if (!clear) begin
      m_phase = 0; m_idx = 0; m_wcnt = 0; m_op = '0; m_valid = 1'b1;
      prog.delete();
    end else if (m_valid) begin
      if (m_phase != 1) begin
        if (go) begin
          m_phase = 1; m_idx = 0; m_wcnt = 0;
          prog.delete();
          prog.push_back(S_T0); prog.push_back(S_T1); prog.push_back(S_WM);
          prog.push_back(S_T2); prog.push_back(S_T3);
        end
      end else begin
        s = prog[m_idx];
        adv = 1'b1;
        if (s == S_WM || s == S_WA) begin
          m_wcnt++;
          adv = (s == S_WM) ? mem_finished : alu_finished;
          if (!adv && m_wcnt == MT) m_phase = 2;
        end
        if (s == S_T2) begin
          m_op = opcode;
          if (m_op == 5'b00000) begin
            prog.push_back(S_T4); prog.push_back(S_WA); prog.push_back(S_T5);
            prog.push_back(S_T6); prog.push_back(S_WM); prog.push_back(S_T7);
            prog.push_back(S_DN);
          end else if (m_op == 5'b00001) begin
            prog.push_back(S_T4); prog.push_back(S_WA); prog.push_back(S_T5);
            prog.push_back(S_DN);
          end else if (m_op == 5'b00010) begin
            prog.push_back(S_T4); prog.push_back(S_WA); prog.push_back(S_T5);
            prog.push_back(S_T6); prog.push_back(S_T7); prog.push_back(S_WM);
            prog.push_back(S_DN);
          end
        end
        if (adv && m_phase == 1) begin
          m_wcnt = 0;
          m_idx++;
          if (m_idx == prog.size()) m_phase = (s == S_DN) ? 0 : 2;
        end
      end
    end
  endtask

  // bit order: PCout IncPC MARin Read Write MDRin MDRout IRin Gra Grb BAout
  //            Rout Rin RYin Immout RZin RZLOout start  (17 .. 0)
  function automatic logic [17:0] step_ctrl(input int v, input logic [4:0] op);
    logic [17:0] c;
    c = '0;
    case (v)
      S_T0: c[16] = 1'b1;
      S_T1: begin c[17] = 1'b1; c[15] = 1'b1; c[14] = 1'b1; c[12] = 1'b1; end
      S_T2: begin c[11] = 1'b1; c[10] = 1'b1; end
      S_T3: begin c[8] = 1'b1; c[7] = 1'b1; c[6] = 1'b1; c[4] = 1'b1; end
      S_T4: begin c[3] = 1'b1; c[2] = 1'b1; end
      S_T5: begin
        c[1] = 1'b1;
        if (op == 5'b00001) begin c[9] = 1'b1; c[5] = 1'b1; end
        else c[15] = 1'b1;
      end
      S_T6: begin
        if (op == 5'b00000) begin c[14] = 1'b1; c[12] = 1'b1; end
        else begin c[9] = 1'b1; c[6] = 1'b1; c[12] = 1'b1; end
      end
      S_T7: begin
        if (op == 5'b00000) begin c[11] = 1'b1; c[9] = 1'b1; c[5] = 1'b1; end
        else c[13] = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [26:0] model_vec();
    int s, v;
    logic [17:0] c;
    if (m_phase == 0) return '0;
    if (m_phase == 2) return 27'd1;
    s = prog[m_idx];
    v = (s == S_WM) ? prog[m_idx-1] : (s == S_WA) ? S_T4 : s;
    c = step_ctrl(v, m_op);
    if (s == S_T4) c[0] = 1'b1;
    return {c, (v == S_T4) ? 6'b000100 : 6'b000000, 1'b1, (s == S_DN), 1'b0};
  endfunction

  initial forever begin
    @(posedge Clock);
    model_step();
  end

  initial forever begin
    @(negedge Clock);
    if (m_valid) begin
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, dut_vec, model_vec());
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  int          s_first_busy, s_done_off, s_done_cnt, s_err_off, s_busy_at_err;
  int          s_read, s_write, s_start, s_imm, s_ldi5, s_st6;
  logic [26:0] s_last;

  // Starts at a negedge with the DUT idle; go is applied in cycle 0.
  task automatic run_instr(input logic [4:0] op, input int m0, input int m1,
                           input int a0, input bit zl, input int ncyc, input int gb);
    s_first_busy = -1; s_done_off = -1; s_done_cnt = 0; s_err_off = -1;
    s_busy_at_err = -1; s_read = 0; s_write = 0; s_start = 0; s_imm = 0;
    s_ldi5 = 0; s_st6 = 0; s_last = '0;
    opcode = op;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) begin
        if (busy && s_first_busy < 0) s_first_busy = k;
        if (done) begin
          s_done_cnt++;
          if (s_done_off < 0) s_done_off = k;
        end
        if (error && s_err_off < 0) begin
          s_err_off = k;
          s_busy_at_err = busy ? 1 : 0;
        end
        s_read  += Read ? 1 : 0;
        s_write += Write ? 1 : 0;
        s_start += start ? 1 : 0;
        s_imm   += Immout ? 1 : 0;
        s_ldi5  += (Gra && Rin && RZLOout) ? 1 : 0;
        s_st6   += (Gra && Rout && MDRin && !Read) ? 1 : 0;
        s_last  = dut_vec;
      end
      if (k == ncyc) break;
      go           = (k == 0) || (k == gb);
      mem_finished = zl || (k == m0) || (k == m1);
      alu_finished = zl || (k == a0);
      @(negedge Clock);
    end
    go = 1'b0; mem_finished = 1'b0; alu_finished = 1'b0;
  endtask

  task automatic reset_dut();
    clear = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    clear = 1'b0; go = 1'b0; opcode = '0; mem_finished = 1'b0; alu_finished = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_outputs", int'(dut_vec), 0);
    clear = 1'b1;
    @(negedge Clock);

    // LD: first read finishes on its 3rd wait cycle, ALU right away, go pulsed while busy
    run_instr(OP_LD, 5, 12, 9, 1'b0, 16, 4);
    chk("ld_first_busy", s_first_busy, 1);
    chk("ld_done_span", s_done_off - s_first_busy, 13);
    chk("ld_done_count", s_done_cnt, 1);
    chk("ld_read_cycles", s_read, 6);
    chk("ld_write_cycles", s_write, 0);
    chk("ld_start_cycles", s_start, 1);

    run_instr(OP_LDI, -1, -1, -1, 1'b1, 11, -1);
    chk("ldi_done_span", s_done_off - s_first_busy, 8);
    chk("ldi_read_cycles", s_read, 2);
    chk("ldi_write_cycles", s_write, 0);
    chk("ldi_t5_gra_rin_rzlo", s_ldi5, 1);
    chk("ldi_done_count", s_done_cnt, 1);

    run_instr(OP_ST, -1, -1, -1, 1'b1, 14, -1);
    chk("st_write_cycles", s_write, 2);
    chk("st_t6_gra_rout_mdrin", s_st6, 1);
    chk("st_read_cycles", s_read, 2);
    chk("st_done_span", s_done_off - s_first_busy, 11);

    // finish arriving on the last allowed wait cycle wins over timeout
    run_instr(OP_LDI, 12, -1, 16, 1'b0, 20, -1);
    chk("edge_no_error", s_err_off, -1);
    chk("edge_done_off", s_done_off, 18);

    // memory never answers
    run_instr(OP_LD, -1, -1, -1, 1'b0, 14, -1);
    chk("to_err_span", s_err_off - s_first_busy, 12);
    chk("to_busy_at_err", s_busy_at_err, 0);
    go = 1'b1;
    @(negedge Clock);
    go = 1'b0;
    chk("to_error_cleared", error ? 1 : 0, 0);
    chk("to_restart_incpc", IncPC ? 1 : 0, 1);
    reset_dut();

    run_instr(5'b11111, -1, -1, -1, 1'b1, 8, -1);
    chk("bad_op_err_off", s_err_off, 6);
    chk("bad_op_start", s_start, 0);
    chk("bad_op_immout", s_imm, 0);
    reset_dut();

    // reset in WAIT_ALU beats go and finished in the same cycle
    run_instr(OP_LD, 3, -1, -1, 1'b0, 8, -1);
    chk("wa_hold_outputs", int'(s_last), 32'h1824);
    clear = 1'b0; go = 1'b1; alu_finished = 1'b1; mem_finished = 1'b1;
    @(negedge Clock);
    chk("wa_reset_outputs", int'(dut_vec), 0);
    clear = 1'b1; go = 1'b0; alu_finished = 1'b0; mem_finished = 1'b0;
    @(negedge Clock);
    chk("idle_after_reset", int'(dut_vec), 0);

    for (int i = 0; i < 4000; i++) begin
      case ($urandom % 5)
        0: opcode = OP_LD;
        1: opcode = OP_LDI;
        2: opcode = OP_ST;
        3: opcode = 5'b11111;
        default: opcode = 5'($urandom);
      endcase
      clear        = ($urandom % 97) != 0;
      go           = ($urandom % 3) == 0;
      mem_finished = ($urandom % 4) == 0;
      alu_finished = ($urandom % 4) == 0;
      @(negedge Clock);
    end
    clear = 1'b1; go = 1'b0;
    @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
